// File: rtl/wb_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter_pkg
//   Shared definitions for the two-master Wishbone RAM arbiter.
//   - arb_state_e   : one-hot arbiter state encoding (IDLE, GNT0, GNT1, DRAIN)
//   - MST0 / MST1   : master index constants, used for the `last` owner bit
//   - DEF_TO_CYCLES : default stall-timeout length
//                     (only used when WB_RAM_ARB_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package wb_ram_arbiter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_GNT0  = 4'b0010,
        ST_GNT1  = 4'b0100,
        ST_DRAIN = 4'b1000
    } arb_state_e;

    localparam logic MST0 = 1'b0;
    localparam logic MST1 = 1'b1;

    localparam int DEF_TO_CYCLES = 64;

endpackage

// File: rtl/wb_ram_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter_rr_pick2
//   Combinational 2-way round-robin picker.
//   Ports:
//     req  [1:0]  in   request per master
//     last        in   index of the master granted most recently
//     gnt  [1:0]  out  one-hot grant (all zero when nothing requests)
//   On a tie the master that was NOT granted last wins.
// -----------------------------------------------------------------------------
module wb_ram_arbiter_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter
//   Two-master to one-slave Wishbone arbiter in front of the byte-serialising
//   on-chip RAM bridge. Master 0 is the instruction bus, master 1 the data bus.
//   Round-robin arbitration; a grant is held for the whole bus cycle (cyc high).
//   Slave-side outputs are combinational muxes of the granted master and are
//   all zero when no master is granted.
//
//   Parameters:
//     DW         data width
//     AW         address width
//     TO_CYCLES  stall cycles before a timeout error (timeout build only)
//
//   Ports:
//     wb_clk_i, wb_rst_ni            clock, asynchronous active-low reset
//     m0_* / m1_*  (adr,dat,sel,we,cyc,stb in; dat,ack,err out)  masters
//     s_*_o (adr,dat,sel,we,cyc,stb)                            to RAM bridge
//     s_dat_i, s_ack_i, s_err_i                                 from RAM bridge
//
//   Build option:
//     WB_RAM_ARB_TIMEOUT_EN  adds a stall counter: if the granted master strobes
//     for TO_CYCLES cycles without ack/err it gets a one-cycle error and the
//     arbiter parks in DRAIN (slave deselected) until that master drops cyc.
//     Without it a hung slave holds the grant indefinitely.
// -----------------------------------------------------------------------------
module wb_ram_arbiter
    import wb_ram_arbiter_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    arb_state_e state, state_nxt;
    logic       last, last_nxt;
    logic [1:0] pick_gnt;
    logic       to_hit;

    // Read data is broadcast; ack/err gating alone tells a master it is served.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_ram_arbiter_rr_pick2 u_pick (
        .req  ({m1_cyc_i, m0_cyc_i}),
        .last (last),
        .gnt  (pick_gnt)
    );

`ifdef WB_RAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES) + 1;

    logic [CW-1:0] to_cnt;
    logic          stalled;

    // A stall cycle: granted, strobing, and the slave has not answered yet.
    assign stalled = ((state == ST_GNT0) || (state == ST_GNT1)) &&
                     s_stb_o && !s_ack_i && !s_err_i;
    assign to_hit  = stalled && (to_cnt == CW'(TO_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_cnt <= '0;
        end else if (stalled && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    logic unused_to_cycles;

    assign to_hit           = 1'b0;
    assign unused_to_cycles = (TO_CYCLES > 0);
`endif

    // State register: reset leaves `last` at master 1 so master 0 wins the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
            last  <= MST1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next state and slave-side mux.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (pick_gnt[0]) begin
                    state_nxt = ST_GNT0;
                    last_nxt  = MST0;
                end else if (pick_gnt[1]) begin
                    state_nxt = ST_GNT1;
                    last_nxt  = MST1;
                end
            end

            ST_GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | to_hit;
                // Releasing to IDLE first gives the deliberate one-cycle bubble.
                if (!m0_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (to_hit) begin
                    state_nxt = ST_DRAIN;
                end
            end

            ST_GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | to_hit;
                if (!m1_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (to_hit) begin
                    state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
`ifdef WB_RAM_ARB_TIMEOUT_EN
                // `last` still names the master that timed out.
                if ((last == MST0) ? !m0_cyc_i : !m1_cyc_i) begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   m0_adr, m1_adr;
    logic [DW-1:0]   m0_dat, m1_dat;
    logic [DW/8-1:0] m0_sel, m1_sel;
    logic            m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;

    wb_ram_arbiter #(.DW(DW), .AW(AW), .TO_CYCLES(TO)) dut (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat),   .m0_sel_i (m0_sel),
        .m0_we_i  (m0_we),    .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat),   .m1_sel_i (m1_sel),
        .m1_we_i  (m1_we),    .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave model: answers after slv_lat strobe cycles unless hung.
    int          slv_lat = 1;
    bit          slv_hang = 1'b0;
    bit          slv_err_mode = 1'b0;
    bit          slv_ovr_en = 1'b0;
    logic [31:0] slv_ovr = '0;
    int          slv_cnt;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack_i <= 1'b0;
            s_err_i <= 1'b0;
            s_dat_i <= '0;
            slv_cnt <= 0;
        end else if (s_cyc_o && s_stb_o && !s_ack_i && !s_err_i) begin
            if (!slv_hang && slv_cnt >= slv_lat - 1) begin
                slv_cnt <= 0;
                if (slv_err_mode) s_err_i <= 1'b1;
                else              s_ack_i <= 1'b1;
                s_dat_i <= slv_ovr_en ? slv_ovr : model_rd(s_adr_o);
                cap_dat <= s_dat_o;
                cap_sel <= s_sel_o;
            end else begin
                slv_cnt <= slv_cnt + 1;
            end
        end else begin
            s_ack_i <= 1'b0;
            s_err_i <= 1'b0;
            slv_cnt <= 0;
        end
    end

    // Scoreboard: expectations pushed at issue, popped on each master ack.
    typedef struct {
        int          m;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_push = 0;
    int   n_ack  = 0;

    task automatic push_exp(input int m, input logic [31:0] dat);
        exp_t e;
        e.m   = m;
        e.dat = dat;
        sb_q.push_back(e);
        n_push++;
    endtask

    always @(negedge clk) begin
        if (rst_n && (m0_ack_o || m1_ack_o)) begin
            n_ack++;
            chk("ack_excl", 32'(m0_ack_o & m1_ack_o), 32'd0);
            chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("sb_master", m1_ack_o ? 32'd1 : 32'd0, 32'(mon_e.m));
                chk("sb_data", m0_ack_o ? m0_dat_o : m1_dat_o, mon_e.dat);
            end
        end
    end

    task automatic start(input int m, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_adr = adr; m0_we = we; m0_dat = dat; m0_sel = sel; m0_cyc = 1'b1; m0_stb = 1'b1;
        end else begin
            m1_adr = adr; m1_we = we; m1_dat = dat; m1_sel = sel; m1_cyc = 1'b1; m1_stb = 1'b1;
        end
    endtask

    task automatic stop(input int m);
        if (m == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; end
        else        begin m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; end
    endtask

    task automatic wait_resp(input int m, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
        end
        chk({tag, "_resp"}, 32'(seen), 32'd1);
    endtask

    task automatic xfer(input int m, input logic [31:0] adr, input string tag);
        start(m, adr, 1'b0, '0, 4'hF);
        wait_resp(m, tag);
        @(posedge clk); #1;
        stop(m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stop(0); stop(1);
        m0_adr = '0; m1_adr = '0; m0_dat = '0; m1_dat = '0; m0_sel = '0; m1_sel = '0;

        // Reset state
        #12;
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("rst_s_we",  32'(s_we_o),  32'd0);
        chk("rst_s_adr", s_adr_o, 32'd0);
        chk("rst_acks",  32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Master 0 solo read, slave answers after 6 cycles
        slv_lat = 6; slv_ovr_en = 1'b1; slv_ovr = 32'hDEADBEEF;
        @(posedge clk); #1;
        push_exp(0, 32'hDEADBEEF);
        start(0, 32'h0000_0010, 1'b0, '0, 4'hF);
        @(negedge clk); chk("t1_cyc_pre", 32'(s_cyc_o), 32'd0);
        @(negedge clk); chk("t1_cyc_lat", 32'(s_cyc_o), 32'd1);
        chk("t1_adr", s_adr_o, 32'h0000_0010);
        wait_resp(0, "t1");
        chk("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
        chk("t1_m1_ack", 32'(m1_ack_o), 32'd0);
        chk("t1_bcast", m1_dat_o, 32'hDEADBEEF);
        @(posedge clk); #1; stop(0);
        slv_ovr_en = 1'b0; slv_lat = 1;

        // Simultaneous requests right after reset: m0 first, then bubble, then m1
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(0, model_rd(32'h0000_0020));
        push_exp(1, model_rd(32'h0000_0024));
        start(0, 32'h0000_0020, 1'b0, '0, 4'hF);
        start(1, 32'h0000_0024, 1'b0, '0, 4'hF);
        @(negedge clk); chk("t2_cyc_pre", 32'(s_cyc_o), 32'd0);
        @(negedge clk); chk("t2_m0_first", s_adr_o, 32'h0000_0020);
        wait_resp(0, "t2_m0");
        @(posedge clk); #1; stop(0);
        @(negedge clk);
        @(negedge clk); chk("t2_bubble", 32'(s_cyc_o), 32'd0);
        @(negedge clk); chk("t2_m1_cyc", 32'(s_cyc_o), 32'd1);
        chk("t2_m1_adr", s_adr_o, 32'h0000_0024);
        wait_resp(1, "t2_m1");
        @(posedge clk); #1; stop(1);

        // Continuous contention: strict alternation, starting with m0
        for (int k = 0; k < 4; k++) begin
            push_exp(0, model_rd(32'h100 + 32'(k * 4)));
            push_exp(1, model_rd(32'h300 + 32'(k * 4)));
        end
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(0, 32'h100 + 32'(i * 4), "t3_m0");
                    @(posedge clk); #1;
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    xfer(1, 32'h300 + 32'(j * 4), "t3_m1");
                    @(posedge clk); #1;
                end
            end
        join
        chk("t3_all_acked", 32'(sb_q.size()), 32'd0);

        // Write passthrough from m1
        slv_lat = 3;
        @(posedge clk); #1;
        push_exp(1, model_rd(32'h0000_0204));
        start(1, 32'h0000_0204, 1'b1, 32'h12345678, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        chk("t4_adr", s_adr_o, 32'h0000_0204);
        chk("t4_dat", s_dat_o, 32'h12345678);
        chk("t4_sel", 32'(s_sel_o), 32'h3);
        chk("t4_we",  32'(s_we_o), 32'd1);
        chk("t4_stb", 32'(s_stb_o), 32'd1);
        wait_resp(1, "t4");
        @(posedge clk); #1; stop(1);
        chk("t4_cap_dat", cap_dat, 32'h12345678);
        chk("t4_cap_sel", 32'(cap_sel), 32'h3);

        // Slave error goes to the granted master only
        slv_err_mode = 1'b1; slv_lat = 2;
        @(posedge clk); #1;
        start(0, 32'h0000_0060, 1'b0, '0, 4'hF);
        wait_resp(0, "t5");
        chk("t5_m0_err", 32'(m0_err_o), 32'd1);
        chk("t5_m0_ack", 32'(m0_ack_o), 32'd0);
        chk("t5_m1_err", 32'(m1_err_o), 32'd0);
        @(posedge clk); #1; stop(0);
        slv_err_mode = 1'b0; slv_lat = 1;

        // Reset in the middle of a hung m0 transfer
        slv_hang = 1'b1;
        @(posedge clk); #1;
        start(0, 32'h0000_0040, 1'b0, '0, 4'hF);
        repeat (3) @(negedge clk);
        chk("t6_cyc_before", 32'(s_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cyc_async", 32'(s_cyc_o), 32'd0);
        chk("t6_stb_async", 32'(s_stb_o), 32'd0);
        chk("t6_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        stop(0);
        slv_hang = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(0, model_rd(32'h0000_0044));
        push_exp(1, model_rd(32'h0000_0048));
        start(0, 32'h0000_0044, 1'b0, '0, 4'hF);
        start(1, 32'h0000_0048, 1'b0, '0, 4'hF);
        @(negedge clk);
        @(negedge clk); chk("t6_last_rst", s_adr_o, 32'h0000_0044);
        wait_resp(0, "t6_m0");
        @(posedge clk); #1; stop(0);
        wait_resp(1, "t6_m1");
        @(posedge clk); #1; stop(1);

`ifdef WB_RAM_ARB_TIMEOUT_EN
        // Stall timeout: error on the TO-th strobe cycle, then drain
        begin
            int  stb_cycles = 0;
            bit  got_err = 1'b0;
            slv_hang = 1'b1;
            @(posedge clk); #1;
            start(0, 32'h0000_0080, 1'b0, '0, 4'hF);
            for (int i = 0; i < 40 && !got_err; i++) begin
                @(negedge clk);
                if (s_stb_o) stb_cycles++;
                got_err = m0_err_o;
            end
            chk("t7_err_seen", 32'(got_err), 32'd1);
            chk("t7_err_at", 32'(stb_cycles), 32'(TO));
            @(posedge clk); #1;
            start(1, 32'h0000_0088, 1'b0, '0, 4'hF);
            @(negedge clk);
            chk("t7_err_pulse", 32'(m0_err_o), 32'd0);
            chk("t7_drain_cyc", 32'(s_cyc_o), 32'd0);
            @(negedge clk); chk("t7_drain_hold", 32'(s_cyc_o), 32'd0);
            slv_hang = 1'b0;
            push_exp(1, model_rd(32'h0000_0088));
            @(posedge clk); #1; stop(0);
            wait_resp(1, "t7_m1");
            @(posedge clk); #1; stop(1);
        end
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("ack_count", 32'(n_ack), 32'(n_push));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
